// File: rtl/hier_pipe_pkg.sv
// hier_pipe_pkg: shared defaults and the count-width helper for the hier_pipe elastic pipeline.
package hier_pipe_pkg;
  localparam int DEF_WIDTH = 1;
  localparam int DEF_DEPTH = 4;
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/hier_pipe_stage.sv
// hier_pipe_stage: one elastic register slot; accepts upstream whenever empty or downstream drains.
module hier_pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             ready_out,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready_in
);
  assign ready_in = !valid || ready_out;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (ready_in) valid <= up_valid;
  // Data is left unreset; valid alone qualifies it.
  always_ff @(posedge clk)
    if (ready_in) data <= up_data;
endmodule

// File: rtl/hier_pipe.sv
// hier_pipe: DEPTH-stage elastic valid/ready pipeline with occupancy count and synchronous flush.
// Defining HIER_PIPE_TAP_EN adds the stage_valid occupancy tap port.
module hier_pipe
  import hier_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [cnt_w(DEPTH)-1:0]    count
`ifdef HIER_PIPE_TAP_EN
  ,
  output logic [DEPTH-1:0]           stage_valid
`endif
);
  localparam int CW = cnt_w(DEPTH);
  logic [DEPTH:0]            v;
  logic [DEPTH:0][WIDTH-1:0] d;
  logic                      push, pop;
  assign v[0] = in_valid;
  assign d[0] = in_data;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic ri, ro;
    // Ready links live per generate scope so the combinational chain stays acyclic per variable.
    if (i == DEPTH - 1) begin : g_tail
      assign ro = out_ready;
    end else begin : g_link
      assign ro = g_stage[i + 1].ri;
    end
    hier_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .up_valid  (v[i]),
      .up_data   (d[i]),
      .ready_out (ro),
      .valid     (v[i + 1]),
      .data      (d[i + 1]),
      .ready_in  (ri)
    );
  end
  assign in_ready  = g_stage[0].ri && !flush;
  assign out_valid = v[DEPTH];
  assign out_data  = d[DEPTH];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= flush ? '0 : count + CW'(push) - CW'(pop);
`ifdef HIER_PIPE_TAP_EN
  assign stage_valid = v[DEPTH:1];
`endif
endmodule

// File: tb/tb_hier_pipe.sv
// tb_hier_pipe: directed self-checking bench for hier_pipe at WIDTH=8, DEPTH=4.
module tb_hier_pipe;
  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] count;
`ifdef HIER_PIPE_TAP_EN
  logic [3:0] stage_valid;
`endif
  int tests = 0;
  int fails = 0;

  hier_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef HIER_PIPE_TAP_EN
    ,
    .stage_valid (stage_valid)
`endif
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #12;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task test_stream;
    int ec;
    out_ready = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      in_valid = k < 8;
      in_data  = 8'(k + 1);
      #1;
      ec = ((k < 8) ? k : 8) - (((k < 12) ? k : 12) > 4 ? ((k < 12) ? k : 12) - 4 : 0);
      tests++; if (count !== 3'(ec)) begin fails++; $display("FAIL stream_count k=%0d got %0d exp %0d", k, count, ec); end
      tests++; if (out_valid !== (k >= 4 && k <= 11)) begin fails++; $display("FAIL stream_valid k=%0d got %b", k, out_valid); end
      if (k >= 4 && k <= 11) begin
        tests++; if (out_data !== 8'(k - 3)) begin fails++; $display("FAIL stream_data k=%0d got %h exp %h", k, out_data, 8'(k - 3)); end
      end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready k=%0d got %b exp 1", k, in_ready); end
      tick;
    end
    in_valid = 1'b0;
  endtask

  task test_backpressure;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(k);
      #1;
      tests++; if (in_ready !== (k < 4)) begin fails++; $display("FAIL bp_in_ready k=%0d got %b exp %b", k, in_ready, k < 4); end
      tests++; if (count !== 3'(k)) begin fails++; $display("FAIL bp_count k=%0d got %0d exp %0d", k, count, k); end
      tick;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (count !== 3'd4) begin fails++; $display("FAIL bp_hold_count got %0d exp 4", count); end
      tests++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin fails++; $display("FAIL bp_hold_data got %b/%h exp 1/10", out_valid, out_data); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_in_ready got %b exp 0", in_ready); end
      tick;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++; if (out_valid !== (k < 4)) begin fails++; $display("FAIL bp_drain_valid k=%0d got %b", k, out_valid); end
      if (k < 4) begin
        tests++; if (out_data !== 8'h10 + 8'(k)) begin fails++; $display("FAIL bp_drain_data k=%0d got %h exp %h", k, out_data, 8'h10 + 8'(k)); end
      end
      tick;
    end
  endtask

  task test_full_pushpop;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'h20 + 8'(k);
      tick;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'h24 + 8'(k);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_in_ready k=%0d got %b exp 1", k, in_ready); end
      tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_count k=%0d got %0d exp 4", k, count); end
      tests++; if (out_data !== 8'h20 + 8'(k)) begin fails++; $display("FAIL full_data k=%0d got %h exp %h", k, out_data, 8'h20 + 8'(k)); end
      tick;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (out_valid !== 1'b1 || out_data !== 8'h24 + 8'(k)) begin fails++; $display("FAIL full_drain k=%0d got %b/%h exp 1/%h", k, out_valid, out_data, 8'h24 + 8'(k)); end
      tests++; if (count !== 3'(4 - k)) begin fails++; $display("FAIL full_drain_count k=%0d got %0d exp %0d", k, count, 4 - k); end
      tick;
    end
  endtask

  task test_flush;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(k);
      tick;
    end
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    flush = 1'b1; in_data = 8'h33; out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    tick;
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL flush_count got %0d exp 0", count); end
    for (int k = 0; k < 6; k++) begin
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost k=%0d got %b/%h exp 0", k, out_valid, out_data); end
      tick;
    end
    for (int k = 0; k <= 5; k++) begin
      in_valid = k == 0; in_data = 8'h34;
      #1;
      tests++; if (out_valid !== (k == 4)) begin fails++; $display("FAIL flush_after_valid k=%0d got %b", k, out_valid); end
      if (k == 4) begin
        tests++; if (out_data !== 8'h34) begin fails++; $display("FAIL flush_after_data got %h exp 34", out_data); end
      end
      tick;
    end
    in_valid = 1'b0;
  endtask

  task test_reset_mid;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 8'h40 + 8'(k);
      tick;
    end
    in_valid = 1'b0;
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL rstmid_pre_count got %0d exp 2", count); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL rstmid_clear got %b/%0d exp 0/0", out_valid, count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready); end
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      in_valid = k == 0; in_data = 8'hA5;
      #1;
      tests++; if (out_valid !== (k == 4)) begin fails++; $display("FAIL rstmid_valid k=%0d got %b", k, out_valid); end
      if (k == 4) begin
        tests++; if (out_data !== 8'hA5) begin fails++; $display("FAIL rstmid_data got %h exp a5", out_data); end
      end
      tick;
    end
    in_valid = 1'b0;
  endtask

`ifdef HIER_PIPE_TAP_EN
  task test_tap;
    out_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      in_valid = k == 0; in_data = 8'h5A;
      #1;
      tests++; if (stage_valid !== ((k >= 1 && k <= 4) ? 4'(1 << (k - 1)) : 4'b0000)) begin fails++; $display("FAIL tap_walk k=%0d got %b", k, stage_valid); end
      tick;
    end
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_full_pushpop;
    test_flush;
    test_reset_mid;
`ifdef HIER_PIPE_TAP_EN
    test_tap;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hier_pipe.md
HIER_PIPE -- requirements
Module: hier_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning the data bits per stage (legal range >= 1).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of register stages (legal range >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of all stages.
REQ-006 SHALL have port in_data  input  WIDTH  upstream data.
REQ-007 SHALL have port in_valid  input  1  upstream data valid.
REQ-008 SHALL have port in_ready  output  1  stage 0 can accept.
REQ-009 SHALL have port out_data  output  WIDTH  data of the last stage.
REQ-010 SHALL have port out_valid  output  1  last stage holds data.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of occupied stages.
REQ-013 SHALL have port stage_valid  output  DEPTH  per-stage occupancy, with bit 0 = input stage; present only per REQ-027.

Function
REQ-014 SHALL implement a DEPTH-stage elastic register pipeline; each stage holds one valid bit and a WIDTH-bit data register.
REQ-015 SHALL compute ready_i = !valid_i || ready_(i+1), with ready_DEPTH = out_ready; in_ready = ready_0 && !flush.
REQ-016 SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-017 SHALL load stage i from stage i-1 (or from in_data when i=0) when ready_i; valid_i then takes the upstream valid.
REQ-018 SHALL give a latency of exactly DEPTH cycles from input transfer to out_valid when out_ready stays high.
REQ-019 SHALL sustain one transfer per cycle in steady state (full throughput, no bubbles inserted).
REQ-020 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL update count by +1 on input-only transfer, -1 on output-only transfer, and 0 on both or neither; count never exceeds DEPTH.
REQ-022 SHALL, when full (count = DEPTH) and out_ready low, drive in_ready low; with out_ready high, in_ready stays high and a simultaneous push/pop keeps count = DEPTH.
REQ-023 SHALL, when empty, drive out_valid low; out_data is don't-care.
REQ-024 SHALL, on flush, clear all valid bits and count to 0 at the next edge; flush wins over a simultaneous push and pop, and no transfer is counted in that cycle.
REQ-025 SHALL preserve data order; no duplication or loss except by flush or reset.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all valid bits and count; out_valid = 0, in_ready = 1 (when flush is low), and data registers are not reset. Mid-operation reset discards contents; operation resumes on the first edge after deassertion.

Configuration
REQ-027 SHALL, when HIER_PIPE_TAP_EN is defined, expose stage_valid driven directly from the stage valid bits; when it is undefined, the port and its logic SHALL be absent and all other behaviour unchanged.

Structure
REQ-028 SHALL place the count-width helper function and the default WIDTH/DEPTH constants in shared package hier_pipe_pkg.
REQ-029 SHALL implement each stage as sub-module hier_pipe_stage (valid, data, ready_in/ready_out), instantiated DEPTH times with a generate loop.
REQ-030 SHALL contain count logic and the flush/in_ready gating at top level only.

Verification (WIDTH=8, DEPTH=4)
REQ-031 SHALL check streaming: push 0x01..0x08 on consecutive cycles with out_ready=1 -> out_data 0x01 at cycle 4, then one word per cycle; count stays 4.
REQ-032 SHALL check backpressure: out_ready=0 with 5 pushes offered -> 4 accepted, in_ready=0, count=4, out_data=first word stable; release -> order intact.
REQ-033 SHALL check simultaneous push/pop when full with out_ready=1 -> count remains 4 and no word is lost.
REQ-034 SHALL check flush with in_valid=1 on the same cycle when count=3 -> next cycle count=0 and out_valid=0; the flushed-cycle word never appears.
REQ-035 SHALL check reset asserted mid-stream with count=2 -> immediate out_valid=0 and count=0; after release, push 0xA5 -> out at cycle 4.
REQ-036 SHALL check that with HIER_PIPE_TAP_EN defined, after a single push stage_valid walks 0001->0010->0100->1000.
